// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_BYPASS} wb_src_e;

  // Register 0 is hard-wired, so it never shows up as pending.
  function automatic logic [(1<<REG_ADDR_W)-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    addr_onehot = '0;
    if (a != '0) addr_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; exposes per-entry valid/addr for hazard masks.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  wb_req_t                             push_req,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic                                full,
  output logic                                empty,
  output logic [CW-1:0]                       count,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_addr
);
  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  assign head  = r_mem[r_rd];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr] <= push_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] w_off;
    assign w_off        = AW'(i) - r_rd;
    assign ent_valid[i] = ({1'b0, w_off} < r_count);
    assign ent_addr[i]  = r_mem[i].addr;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and variable-latency writebacks onto the single regfile write port.
// Optional WB_FWD_EN adds a same-cycle write-through forwarding port.
module regfile_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_ADDR_W-1:0]  alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [REG_ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   wen,
  output logic [REG_ADDR_W-1:0]  write_addr,
  output logic [DATA_W-1:0]      write_data,
  output logic [31:0]            pending_mask,
`ifdef WB_FWD_EN
  input  logic [REG_ADDR_W-1:0]  fwd_addr,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t                          w_head;
  wb_req_t                          w_sel;
  wb_src_e                          w_src;
  logic                             w_full, w_empty;
  logic                             w_alu_go, w_pop, w_byp, w_push;
  logic [DEPTH-1:0]                 w_ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_ent_addr;
  logic [31:0]                      w_mask;

  logic                  r_wen;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_data;
  logic [SW-1:0]         r_starve;

  assign mem_ready = !w_full;
  assign alu_ready = !(!w_empty && r_starve == SW'(STARVE_LIMIT));

  assign w_alu_go = alu_valid && alu_ready;
  assign w_pop    = !w_alu_go && !w_empty;
  assign w_byp    = !w_alu_go && w_empty && mem_valid;
  assign w_push   = mem_valid && mem_ready && !w_byp;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_req  ({mem_addr, mem_data}),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count),
    .ent_valid (w_ent_valid),
    .ent_addr  (w_ent_addr)
  );

  always_comb begin
    w_src = SRC_NONE;
    w_sel = '0;
    if (w_alu_go) begin
      w_src = SRC_ALU;
      w_sel = '{addr: alu_addr, data: alu_data};
    end else if (w_pop) begin
      w_src = SRC_FIFO;
      w_sel = w_head;
    end else if (w_byp) begin
      w_src = SRC_BYPASS;
      w_sel = '{addr: mem_addr, data: mem_data};
    end
  end

  // Writes to r0 still take the slot but never assert wen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wen <= (w_src != SRC_NONE) && (w_sel.addr != '0);
      if (w_src != SRC_NONE) begin
        r_addr <= w_sel.addr;
        r_data <= w_sel.data;
      end
    end
  end

  // Counts consecutive ALU wins over a waiting FIFO head.
  always_ff @(posedge clk) begin
    if (reset || w_empty || w_pop) r_starve <= '0;
    else if (w_alu_go && r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_ent_valid[i]) w_mask |= addr_onehot(w_ent_addr[i]);
    if (r_wen) w_mask |= addr_onehot(r_addr);
  end

  assign pending_mask = w_mask;
  assign wen          = r_wen;
  assign write_addr   = r_addr;
  assign write_data   = r_data;

`ifdef WB_FWD_EN
  assign fwd_hit  = r_wen && (r_addr == fwd_addr) && (fwd_addr != '0);
  assign fwd_data = fwd_hit ? r_data : '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write-order scoreboard.
module tb_regfile_write_arbiter;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        wen;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  wb_req_t exp_q[$];

  regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .wen          (wen),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .pending_mask (pending_mask),
`ifdef WB_FWD_EN
    .fwd_addr     (fwd_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
`endif
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_alu(input logic [4:0] a, input logic [31:0] d);
    alu_valid = 1'b1; alu_addr = a; alu_data = d;
  endtask

  task automatic drv_mem(input logic [4:0] a, input logic [31:0] d);
    mem_valid = 1'b1; mem_addr = a; mem_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Every write pulse must match the next predicted write.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_wen_addr", 32'(write_addr), 32'hFFFF_FFFF);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(write_addr), 32'(e.addr));
        chk("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
`ifdef WB_FWD_EN
    fwd_addr = '0;
`endif
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_wen",     32'(wen), 32'd0);
    chk("rst_pending", pending_mask, 32'd0);
    chk("rst_count",   32'(fifo_count), 32'd0);
    chk("rst_memrdy",  32'(mem_ready), 32'd1);
    chk("rst_alurdy",  32'(alu_ready), 32'd1);
    chk("rst_waddr",   32'(write_addr), 32'd0);
    chk("rst_wdata",   write_data, 32'd0);

    // ALU only
    drv_alu(5'd5, 32'hDEAD_BEEF); expect_wr(5'd5, 32'hDEAD_BEEF);
    tick(); alu_valid = 1'b0;
    chk("alu_wen",     32'(wen), 32'd1);
    chk("alu_pending", pending_mask, 32'h1 << 5);
    tick();
    chk("alu_wen_once", 32'(wen), 32'd0);
    chk("alu_pend_clr", pending_mask, 32'd0);

    // Bypass with empty FIFO and idle ALU
    drv_mem(5'd7, 32'h77);
    chk("byp_memrdy", 32'(mem_ready), 32'd1);
    expect_wr(5'd7, 32'h77);
    tick(); mem_valid = 1'b0;
    chk("byp_count", 32'(fifo_count), 32'd0);
    chk("byp_wen",   32'(wen), 32'd1);
    tick();

    // Same mem request while ALU busy goes to the FIFO
    drv_alu(5'd3, 32'h33); drv_mem(5'd7, 32'h707);
    expect_wr(5'd3, 32'h33);
    tick(); alu_valid = 1'b0; mem_valid = 1'b0;
    chk("push_count",   32'(fifo_count), 32'd1);
    chk("push_pending", pending_mask, (32'h1 << 7) | (32'h1 << 3));
    expect_wr(5'd7, 32'h707);
    tick();
    chk("pop_count",   32'(fifo_count), 32'd0);
    chk("pop_pending", pending_mask, 32'h1 << 7);
    tick();
    chk("idle_pending", pending_mask, 32'd0);

    // Starvation: one FIFO entry against a continuously valid ALU
    for (int k = 0; k < 4; k++) begin
      drv_alu(5'(20 + k), 32'h100 + 32'(k));
      if (k == 0) drv_mem(5'd11, 32'hB0);
      chk("starve_alurdy", 32'(alu_ready), 32'd1);
      expect_wr(5'(20 + k), 32'h100 + 32'(k));
      tick();
      if (k == 0) begin
        mem_valid = 1'b0;
        chk("starve_count",   32'(fifo_count), 32'd1);
        chk("starve_pending", pending_mask, (32'h1 << 20) | (32'h1 << 11));
      end
    end
    drv_alu(5'd24, 32'h104);
    chk("starve_block", 32'(alu_ready), 32'd0);
    expect_wr(5'd11, 32'hB0);
    tick();
    chk("starve_drain", 32'(fifo_count), 32'd0);
    chk("starve_rel",   32'(alu_ready), 32'd1);
    expect_wr(5'd24, 32'h104);
    tick(); alu_valid = 1'b0;
    tick();

    // Full FIFO: 4 pushes while ALU busy, 5th held until a slot frees
    for (int k = 0; k < 4; k++) begin
      drv_alu(5'(16 + k), 32'h200 + 32'(k));
      drv_mem(5'(25 + k), 32'h300 + 32'(k));
      chk("full_memrdy", 32'(mem_ready), 32'd1);
      expect_wr(5'(16 + k), 32'h200 + 32'(k));
      tick();
    end
    chk("full_count",  32'(fifo_count), 32'd4);
    chk("full_memrdy0", 32'(mem_ready), 32'd0);
    chk("full_alurdy0", 32'(alu_ready), 32'd0);
    drv_alu(5'd30, 32'h204); drv_mem(5'd29, 32'h304);
    expect_wr(5'd25, 32'h300);
    tick();
    chk("full_pop_count", 32'(fifo_count), 32'd3);
    chk("full_memrdy1",   32'(mem_ready), 32'd1);
    expect_wr(5'd30, 32'h204);
    tick(); alu_valid = 1'b0; mem_valid = 1'b0;
    chk("full_refill", 32'(fifo_count), 32'd4);
    for (int k = 1; k < 5; k++) expect_wr(5'(25 + k), 32'h300 + 32'(k));
    repeat (4) tick();
    chk("full_empty", 32'(fifo_count), 32'd0);
    tick();

    // Register 0 consumes a slot but never writes
    drv_alu(5'd0, 32'h55);
    tick(); alu_valid = 1'b0;
    chk("r0_wen",     32'(wen), 32'd0);
    chk("r0_pending", pending_mask, 32'd0);
    tick();

`ifdef WB_FWD_EN
    drv_alu(5'd9, 32'h12); fwd_addr = 5'd9;
    expect_wr(5'd9, 32'h12);
    tick(); alu_valid = 1'b0;
    chk("fwd_hit",  32'(fwd_hit), 32'd1);
    chk("fwd_data", fwd_data, 32'h12);
    fwd_addr = 5'd8; #1;
    chk("fwd_miss",      32'(fwd_hit), 32'd0);
    chk("fwd_miss_data", fwd_data, 32'd0);
    tick();
`endif

    // Reset mid-operation with 3 entries buffered
    for (int k = 0; k < 3; k++) begin
      drv_alu(5'(1 + k), 32'h400 + 32'(k));
      drv_mem(5'(12 + k), 32'h500 + 32'(k));
      expect_wr(5'(1 + k), 32'h400 + 32'(k));
      tick();
    end
    chk("mid_count", 32'(fifo_count), 32'd3);
    alu_valid = 1'b0; mem_valid = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    chk("mid_wen",     32'(wen), 32'd0);
    chk("mid_pending", pending_mask, 32'd0);
    chk("mid_count0",  32'(fifo_count), 32'd0);
    chk("mid_memrdy",  32'(mem_ready), 32'd1);
    tick();
    chk("mid_no_drain", 32'(wen), 32'd0);
    tick();

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
